// File: rtl/arb_tagged_out_queue_if.sv
// Enqueue/dequeue handshake, occupancy and per-source grant counter bundle
// for the tagged arbiter output queue.
interface arb_tagged_out_queue_if #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned CW = $clog2(ENTRIES) + 1;

    logic              io_enq_ready;
    logic              io_enq_valid;
    logic [DATA_W-1:0] io_enq_bits;
    logic [TAG_W-1:0]  io_enq_tag;
    logic              io_deq_ready;
    logic              io_deq_valid;
    logic [DATA_W-1:0] io_deq_bits;
    logic [TAG_W-1:0]  io_deq_tag;
    logic [CW-1:0]     io_count;
    logic              io_clear;
    logic [CNT_W-1:0]  io_grants_0;
    logic [CNT_W-1:0]  io_grants_1;
    logic [CNT_W-1:0]  io_grants_2;
    logic [CNT_W-1:0]  io_grants_3;

    modport slave (
        output io_enq_ready,
        input  io_enq_valid, io_enq_bits, io_enq_tag,
        input  io_deq_ready,
        output io_deq_valid, io_deq_bits, io_deq_tag,
        output io_count,
        input  io_clear,
        output io_grants_0, io_grants_1, io_grants_2, io_grants_3
    );

    modport master (
        input  io_enq_ready,
        output io_enq_valid, io_enq_bits, io_enq_tag,
        output io_deq_ready,
        input  io_deq_valid, io_deq_bits, io_deq_tag,
        input  io_count,
        output io_clear,
        input  io_grants_0, io_grants_1, io_grants_2, io_grants_3
    );
endinterface

// File: rtl/arb_tagged_out_queue.sv
// Small FIFO buffering (payload, source tag) pairs from the round-robin arbiter,
// with saturating per-source counters of accepted grants.
module arb_tagged_out_queue #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned CNT_W   = 8
) (
    input logic                   clk,
    input logic                   reset,
    arb_tagged_out_queue_if.slave io
);
    localparam int unsigned PW   = $clog2(ENTRIES);
    localparam int unsigned NSRC = 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] bits;
    } entry_t;

    entry_t            mem [ENTRIES];
    logic [PW-1:0]     enq_ptr;
    logic [PW-1:0]     deq_ptr;
    logic [PW-1:0]     ptr_diff;
    logic              maybe_full;
    logic              ptr_match;
    logic              full;
    logic              empty;
    logic              enq_fire;
    logic              deq_fire;
    logic [1:0]        grant_idx;
    logic [CNT_W-1:0]  grants [NSRC];

    assign ptr_match = (enq_ptr == deq_ptr);
    assign full      = ptr_match && maybe_full;
    assign empty     = ptr_match && !maybe_full;
    assign enq_fire  = io.io_enq_valid && !full;
    assign deq_fire  = io.io_deq_ready && !empty;
    assign ptr_diff  = enq_ptr - deq_ptr;
    assign grant_idx = 2'(io.io_enq_tag);

    assign io.io_enq_ready = !full;
    assign io.io_deq_valid = !empty;
    assign io.io_deq_bits  = mem[deq_ptr].bits;
    assign io.io_deq_tag   = mem[deq_ptr].tag;
    assign io.io_count     = full ? ($bits(io.io_count))'(ENTRIES) : {1'b0, ptr_diff};

    assign io.io_grants_0 = grants[0];
    assign io.io_grants_1 = grants[1];
    assign io.io_grants_2 = grants[2];
    assign io.io_grants_3 = grants[3];

    // Storage is cleared on reset so the head mux never presents unknowns.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (enq_fire) begin
            mem[enq_ptr] <= '{tag: io.io_enq_tag, bits: io.io_enq_bits};
        end
    end

    // Pointers wrap naturally; maybe_full only moves when exactly one side fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (enq_fire) begin
                enq_ptr <= enq_ptr + PW'(1);
            end
            if (deq_fire) begin
                deq_ptr <= deq_ptr + PW'(1);
            end
            if (enq_fire != deq_fire) begin
                maybe_full <= enq_fire;
            end
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || io.io_clear) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                grants[i] <= '0;
            end
        end else if (enq_fire && (grants[grant_idx] != '1)) begin
            grants[grant_idx] <= grants[grant_idx] + CNT_W'(1);
        end
    end
endmodule

// File: doc/arb_tagged_out_queue.md
Name: arb_tagged_out_queue

Overview:
- Downstream stage for the 4-input round-robin arbiter.
- Accepts the arbiter's granted 8-bit payload together with its 2-bit chosen index, and buffers the pair in a small FIFO for the next consumer.
- Keeps per-source saturating grant counters so software and testbenches can check fairness.
- Decouples the arbiter's grant, and therefore its round-robin pointer update, from consumer backpressure.

Parameters:
- ENTRIES, 4, FIFO depth; power of two, minimum 2.
- DATA_W, 8, payload width.
- TAG_W, 2, source tag width (log2 of arbiter input count).
- CNT_W, 8, width of each grant counter.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- io_enq_ready, output, 1, queue can accept an entry.
- io_enq_valid, input, 1, arbiter out_valid.
- io_enq_bits, input, DATA_W, arbiter out_bits.
- io_enq_tag, input, TAG_W, arbiter chosen.
- io_deq_ready, input, 1, consumer ready.
- io_deq_valid, output, 1, head entry present.
- io_deq_bits, output, DATA_W, head payload.
- io_deq_tag, output, TAG_W, head source tag.
- io_count, output, log2(ENTRIES)+1, current occupancy.
- io_clear, input, 1, zero all grant counters.
- io_grants_0 .. io_grants_3, output, CNT_W each, accepted enqueues per tag value.

Behaviour:
- Handshakes:
  - enq fire = io_enq_valid && io_enq_ready.
  - deq fire = io_deq_valid && io_deq_ready.
  - io_enq_ready = !full; it does not depend on io_deq_ready and has no pipe bypass.
  - io_deq_valid = !empty; no flow-through. An entry written in cycle N is first visible on deq in cycle N+1.
- Storage:
  - ENTRIES x (DATA_W+TAG_W) register array.
  - enq_ptr and deq_ptr are log2(ENTRIES) bits and wrap naturally from ENTRIES-1 to 0.
  - A maybe_full flag disambiguates ptr equality:
    - empty = ptrs equal && !maybe_full.
    - full = ptrs equal && maybe_full.
    - maybe_full is set on enq fire without deq fire, and cleared on deq fire without enq fire.
  - io_deq_bits/io_deq_tag come combinationally from the entry at deq_ptr. Their value is don't-care when empty, but must be stable and never X after reset.
- io_count:
  - Equals enq_ptr-deq_ptr (mod ENTRIES) when not full; equals ENTRIES when full.
  - Updated one cycle after the fire.
- Simultaneous enq and deq fire (only possible when neither empty nor full): both pointers advance, count and maybe_full unchanged.
- Grant counters:
  - On enq fire, io_grants_[io_enq_tag] increments by 1, saturating at 2^CNT_W-1 (stays 255).
  - Only enqueues are counted; dequeues are not.
  - io_clear zeroes all four counters next cycle and wins over a same-cycle increment: that increment is lost, and the counter reads 0.
  - Clear does not affect the FIFO.
- Reset, synchronous, may occur mid-operation:
  - Next cycle: both pointers 0, maybe_full 0, io_deq_valid 0, io_enq_ready 1, io_count 0, all grant counters 0.
  - Enq/deq fires coincident with reset are discarded.
  - Storage contents need not be cleared.
- Full boundary: with io_deq_ready=1 and the queue full, one entry dequeues this cycle; io_enq_ready goes high the following cycle.
- Empty boundary: io_deq_ready is ignored when empty; pointers hold.
- Ordering: strict FIFO, and each tag travels with its payload unchanged.

Test Plan:
- Reset then idle:
  - Response: io_enq_ready=1, io_deq_valid=0, io_count=0, all grants 0.
- Fill and drain (deq_ready=0):
  - Stimulus: enqueue (0x11,tag0),(0x22,tag1),(0x33,tag2),(0x44,tag3).
  - Response: count 1,2,3,4 on successive cycles; io_enq_ready=0 at count 4; a fifth enq is refused and grants stay 1,1,1,1.
  - Then set deq_ready=1: outputs 0x11/0, 0x22/1, 0x33/2, 0x44/3 in order, and count returns to 0.
- Streaming:
  - Stimulus: enq_valid=1 and deq_ready=1 continuously, data incrementing from 0x00.
  - Response: first deq_valid one cycle after first enq; then one entry per cycle; count steady at 1; no loss or duplication over 20 beats.
- Wrap-around:
  - Stimulus: 10 enq/deq pairs with the occupancy pattern 3,2,3,2,...
  - Response: pointers wrap past 3; data order preserved.
- Counter saturation and clear:
  - Stimulus: 300 enqueues of tag1 with continuous drain.
  - Response: io_grants_1=255, others 0. Asserting io_clear together with a tag1 enq gives io_grants_1=0 next cycle.
- Reset mid-operation:
  - Stimulus: queue holds 3 entries, then assert reset for 1 cycle with enq_valid=1.
  - Response: next cycle count=0, deq_valid=0, grants 0; the subsequent first dequeue returns only post-reset data.
